relogio_ctrl: RTL and testbench
===============================

# relogio_ctrl

Mode and time-base controller for the top-down clock. It generates the 1 s time base and issues single-cycle increment pulses to the seconds, minutes and hours BCD counters, including carries driven by their terminal-count flags. It also sequences the user time-setting modes (RUN → SET_H → SET_M), with button edge detection and auto-repeat. The block sits between the debounced push-buttons and the three counter instances.

## Interface
- CLK_DIV, 50_000_000: clock cycles per second tick
- REPEAT_DLY, 25_000_000: cycles `btn_inc` must be held after its edge before auto-repeat starts
- REPEAT_PER, 10_000_000: auto-repeat period in cycles
- BLINK_DIV, 12_500_000: cycles per `visivel` half-period in set modes

- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- btn_mode  in  1  debounced mode button, active-high level
- btn_inc  in  1  debounced increment button, active-high level
- seg_max  in  1  seconds counter currently at 59
- min_max  in  1  minutes counter currently at 59
- incrementa_seg  out  1  one-cycle increment pulse to the seconds counter
- incrementa_min  out  1  one-cycle increment pulse to the minutes counter
- incrementa_hora  out  1  one-cycle increment pulse to the hours counter
- zera_seg  out  1  one-cycle clear pulse to the seconds counter
- modo  out  2  current mode: 0 RUN, 1 SET_H, 2 SET_M
- visivel  out  1  display enable for the field being set (1 = shown)

## Operation
- States: RUN, SET_H, SET_M.
  - Rising edge of `btn_mode`: RUN→SET_H→SET_M→RUN.
  - Value 3 is unreachable; if it occurs, go to RUN.
- Edge detection: edge = level & ~prev. Both `prev` registers reset to 1, so a button held through reset release produces no edge.
- RUN:
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - When the prescaler is at CLK_DIV-1, `incrementa_seg` pulses.
  - In the same cycle, `incrementa_min` pulses if `seg_max`=1.
  - In the same cycle, `incrementa_hora` pulses if `seg_max` & `min_max`.
  - `btn_inc` is ignored. `visivel`=1 constant.
- SET_H and SET_M:
  - Prescaler is held at 0. No `incrementa_seg` and no carries.
  - `btn_inc` edge → one pulse: `incrementa_hora` in SET_H, `incrementa_min` in SET_M. No carry to hours; the minutes counter wraps by itself.
- Auto-repeat: hold counter counts cycles of continuous `btn_inc` high since the edge.
  - First repeat pulse at edge+1+REPEAT_DLY, then every REPEAT_PER cycles.
  - A pulse at cycle E+1+k requires `btn_inc` high in cycle E+k.
  - Release clears the hold counter.
- Leaving SET_M→RUN: `zera_seg` pulses for one cycle and the prescaler restarts from 0.
- `visivel` in set modes:
  - Set to 1 on entering the mode, then toggles every BLINK_DIV cycles.
  - The blink counter clears on every mode change.
- Simultaneous `btn_mode` edge and `btn_inc` edge: the mode change wins, the increment is dropped, and the hold counter clears.
- Counter widths are $clog2 of the respective parameter. Counters wrap only as stated; there is no overflow elsewhere.

## Timing
- Reset values:
  - `modo`=0 (RUN), `visivel`=1.
  - All pulse outputs 0.
  - Prescaler, hold and blink counters 0.
  - prev registers 1.
- All outputs are registered. A condition sampled in cycle N produces an output in cycle N+1.
- After reset release, the first `incrementa_seg` comes CLK_DIV cycles after the first non-reset cycle.
- `modo` updates in the cycle after the sampled `btn_mode` edge. `zera_seg` is coincident with `modo` becoming 0.
- Pulse outputs are never high for two consecutive cycles, except auto-repeat with REPEAT_PER=1, which is not a supported configuration.
- `rst` asserted mid-operation takes effect at the next clock edge. It drops any pending pulse and returns to RUN.

## Structure
- Package `relogio_pkg` holds `modo_t` (RUN=2'd0, SET_H=2'd1, SET_M=2'd2) and the default timing constants.
- Sub-module `repetidor_botao` (parameters REPEAT_DLY and REPEAT_PER):
  - Handles `btn_inc` edge detection, the hold counter and auto-repeat.
  - Output: a one-cycle `inc_req`.
  - Input: `clr`, driven on mode change.
- The FSM, prescaler and blink logic live in `relogio_ctrl`.

## Test plan
Use CLK_DIV=10, REPEAT_DLY=20, REPEAT_PER=5, BLINK_DIV=4.
- Reset, then RUN with `seg_max`=0 → `incrementa_seg` high at cycles 10, 20, 30 after release. No other pulses.
- RUN tick with `seg_max`=1, `min_max`=0 → seg+min pulse in the same cycle. With both set → seg+min+hora pulse in the same cycle.
- Three `btn_mode` edges → `modo` goes 1, 2, 0.
  - On the return to 0, `zera_seg` pulses for one cycle.
  - The next `incrementa_seg` comes exactly 10 cycles later.
- SET_H, `btn_inc` high for cycles 0..39 → `incrementa_hora` at cycles 1, 21, 26, 31, 36 only. `visivel` reads 1,1,1,1,0,0,0,0 over the first 8 cycles after entering the mode, then repeats.
- `btn_mode` and `btn_inc` edges in the same cycle in SET_H → `modo`=2, no `incrementa_hora`.
- `btn_inc` edges in RUN → no increment pulses.
- `rst` pulsed in SET_M with both buttons held through release → `modo`=0, `visivel`=1, no edges detected, no pulses until the first tick.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types and default timing constants for the clock mode/time-base controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package relogio_pkg;

  // Operating mode; encoding is visible on the modo output
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } modo_t;

  localparam int CLK_DIV_DEF    = 50_000_000;
  localparam int REPEAT_DLY_DEF = 25_000_000;
  localparam int REPEAT_PER_DEF = 10_000_000;
  localparam int BLINK_DIV_DEF  = 12_500_000;

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/repetidor_botao.sv
// Increment-button edge detector with hold counter and auto-repeat.
// Latency: inc_req is combinational from the sampled button and state; the parent registers it.
// Backpressure: none; clr drops the hold and disarms repeat until the next fresh edge.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   btn_inc    debounced increment button level
//   clr        mode change in progress: kill any request and clear the hold state
//   inc_req    one-cycle increment request (edge or auto-repeat)
module repetidor_botao
  import relogio_pkg::*;
#(
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc,
  input  logic clr,
  output logic inc_req
);

  // The hold counter must reach whichever of the two intervals is longer
  localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int HOLD_W   = largura(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DLY_V = HOLD_W'(REPEAT_DLY);
  localparam logic [HOLD_W-1:0] PER_V = HOLD_W'(REPEAT_PER);

  logic              prev;
  logic              ativo;      // button held continuously since an accepted edge
  logic              repetindo;  // first repeat already issued, now pacing by REPEAT_PER
  logic [HOLD_W-1:0] hold_cnt;   // cycles since the edge or since the last repeat
  logic              borda;
  logic [HOLD_W-1:0] alvo;

  always_comb begin
    borda   = btn_inc & ~prev;
    alvo    = repetindo ? PER_V : DLY_V;
    inc_req = borda | (ativo & btn_inc & (hold_cnt == alvo));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // prev resets high so a button held through reset is not seen as an edge
      prev      <= 1'b1;
      ativo     <= 1'b0;
      repetindo <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      prev <= btn_inc;
      if (clr || !btn_inc) begin
        ativo     <= 1'b0;
        repetindo <= 1'b0;
        hold_cnt  <= '0;
      end else if (borda) begin
        ativo     <= 1'b1;
        repetindo <= 1'b0;
        hold_cnt  <= HOLD_W'(1);
      end else if (ativo) begin
        if (hold_cnt == alvo) begin
          repetindo <= 1'b1;
          hold_cnt  <= HOLD_W'(1);
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/relogio_ctrl.sv
// Mode FSM, 1 s prescaler and blink generator driving the seconds/minutes/hours BCD counters.
// Latency: every output is registered; a condition sampled in cycle N appears in cycle N+1.
// Backpressure: none; pulses are fire-and-forget single cycles.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   btn_mode, btn_inc    debounced push-button levels
//   seg_max, min_max     terminal-count flags from the seconds and minutes counters
//   incrementa_seg/min/hora  one-cycle increment pulses
//   zera_seg             one-cycle clear of the seconds counter when returning to RUN
//   modo                 current mode (0 RUN, 1 SET_H, 2 SET_M)
//   visivel              blink enable for the field being set
module relogio_ctrl
  import relogio_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF,
  parameter int BLINK_DIV  = BLINK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       seg_max,
  input  logic       min_max,
  output logic       incrementa_seg,
  output logic       incrementa_min,
  output logic       incrementa_hora,
  output logic       zera_seg,
  output logic [1:0] modo,
  output logic       visivel
);

  localparam int PRESC_W = largura(CLK_DIV);
  localparam int BLINK_W = largura(BLINK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  modo_t              estado;
  logic               mode_prev;
  logic [PRESC_W-1:0] presc;
  logic [BLINK_W-1:0] blink_cnt;
  logic               mode_edge;
  logic               tick;
  logic               inc_req;

  assign mode_edge = btn_mode & ~mode_prev;
  assign tick      = (estado == RUN) && (presc == PRESC_MAX);
  assign modo      = estado;

  repetidor_botao #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_repetidor (
    .clk     (clk),
    .rst     (rst),
    .btn_inc (btn_inc),
    .clr     (mode_edge),
    .inc_req (inc_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado          <= RUN;
      mode_prev       <= 1'b1;
      presc           <= '0;
      blink_cnt       <= '0;
      visivel         <= 1'b1;
      incrementa_seg  <= 1'b0;
      incrementa_min  <= 1'b0;
      incrementa_hora <= 1'b0;
      zera_seg        <= 1'b0;
    end else begin
      mode_prev <= btn_mode;

      // Carries ride on the tick; manual increments lose to a simultaneous mode change
      incrementa_seg  <= tick;
      incrementa_min  <= (tick & seg_max) | ((estado == SET_M) & inc_req & ~mode_edge);
      incrementa_hora <= (tick & seg_max & min_max) | ((estado == SET_H) & inc_req & ~mode_edge);
      zera_seg        <= mode_edge & (estado == SET_M);

      // Prescaler only runs while staying in RUN, so re-entering RUN restarts the second
      if ((estado == RUN) && !mode_edge)
        presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      else
        presc <= '0;

      if (mode_edge) begin
        case (estado)
          RUN:     estado <= SET_H;
          SET_H:   estado <= SET_M;
          default: estado <= RUN;
        endcase
        blink_cnt <= '0;
        visivel   <= 1'b1;
      end else if (estado == RUN) begin
        blink_cnt <= '0;
        visivel   <= 1'b1;
      end else if ((estado == SET_H) || (estado == SET_M)) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          visivel   <= ~visivel;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        // Unused encoding: recover to RUN
        estado    <= RUN;
        blink_cnt <= '0;
        visivel   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_relogio_ctrl.sv
// Testbench for relogio_ctrl: directed literal checks plus randomized stimulus against a behavioural model.
// Latency: model predicts outputs one cycle after the sampled inputs.
// Backpressure: n/a.
module tb_relogio_ctrl;
  import relogio_pkg::*;

  localparam int CLK_DIV    = 10;
  localparam int REPEAT_DLY = 20;
  localparam int REPEAT_PER = 5;
  localparam int BLINK_DIV  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       seg_max = 1'b0;
  logic       min_max = 1'b0;
  logic       incrementa_seg;
  logic       incrementa_min;
  logic       incrementa_hora;
  logic       zera_seg;
  logic [1:0] modo;
  logic       visivel;

  relogio_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_mode        (btn_mode),
    .btn_inc         (btn_inc),
    .seg_max         (seg_max),
    .min_max         (min_max),
    .incrementa_seg  (incrementa_seg),
    .incrementa_min  (incrementa_min),
    .incrementa_hora (incrementa_hora),
    .zera_seg        (zera_seg),
    .modo            (modo),
    .visivel         (visivel)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, expv);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode, run_t, set_t, hold_k, nxt;
  bit held, pm, pi, me, ie, req, tck;
  bit e_seg, e_min, e_hora, e_zera, e_vis;
  int e_modo;

  task automatic model_step();
    cyc++;
    if (rst) begin
      m_mode = 0; run_t = 0; set_t = 0; held = 0; hold_k = 0; pm = 1; pi = 1;
      e_seg = 0; e_min = 0; e_hora = 0; e_zera = 0; e_vis = 1; e_modo = 0;
    end else begin
      me = btn_mode && !pm;
      ie = btn_inc && !pi;
      if (!btn_inc) held = 0;
      req = 0;
      if (ie) begin
        req = 1; held = 1; hold_k = 0;
      end else if (held) begin
        hold_k++;
        req = (hold_k >= REPEAT_DLY) && (((hold_k - REPEAT_DLY) % REPEAT_PER) == 0);
      end
      if (me) begin held = 0; req = 0; end
      tck    = (m_mode == 0) && ((run_t % CLK_DIV) == CLK_DIV - 1);
      e_seg  = tck;
      e_min  = (tck && seg_max) || (m_mode == 2 && req);
      e_hora = (tck && seg_max && min_max) || (m_mode == 1 && req);
      e_zera = me && (m_mode == 2);
      nxt    = me ? (m_mode + 1) % 3 : m_mode;
      run_t  = (m_mode == 0 && !me) ? run_t + 1 : 0;
      set_t  = me ? 0 : set_t + 1;
      e_vis  = (nxt == 0) ? 1'b1 : (((set_t / BLINK_DIV) % 2) == 0);
      e_modo = nxt;
      m_mode = nxt;
      pm = btn_mode;
      pi = btn_inc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cmp_modo", {30'd0, modo}, e_modo);
      chk("cmp_vis",  visivel, e_vis);
      chk("cmp_seg",  incrementa_seg, e_seg);
      chk("cmp_min",  incrementa_min, e_min);
      chk("cmp_hora", incrementa_hora, e_hora);
      chk("cmp_zera", zera_seg, e_zera);
    end
  end

  // Press and release btn_mode, checking the mode reached and zera_seg
  task automatic press_mode(input int exp_modo, input bit exp_zera);
    btn_mode = 1'b1;
    @(negedge clk);
    chk("press_modo", {30'd0, modo}, exp_modo);
    chk("press_zera", zera_seg, exp_zera);
    btn_mode = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    // reset state
    chk("rst_modo", {30'd0, modo}, 0);
    chk("rst_vis", visivel, 1);
    chk("rst_pulses", {28'd0, incrementa_seg, incrementa_min, incrementa_hora, zera_seg}, 0);

    // RUN time base: ticks at cycles 10, 20, 30
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      chk("run_seg", incrementa_seg, (c % 10) == 0);
      chk("run_hora", incrementa_hora, 0);
    end

    // carries: seconds at 59, then seconds and minutes at 59
    seg_max = 1'b1;
    repeat (8) @(negedge clk);
    chk("carry1_seg", incrementa_seg, 1);
    chk("carry1_min", incrementa_min, 1);
    chk("carry1_hora", incrementa_hora, 0);
    min_max = 1'b1;
    repeat (10) @(negedge clk);
    chk("carry2", {29'd0, incrementa_seg, incrementa_min, incrementa_hora}, 7);
    seg_max = 1'b0;
    min_max = 1'b0;

    // mode cycle and restart of the second
    press_mode(1, 1'b0);
    press_mode(2, 1'b0);
    press_mode(0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) @(negedge clk);
      chk("rerun_zera", zera_seg, 0);
      chk("rerun_seg", incrementa_seg, i == 10);
    end

    // SET_H: blink pattern and auto-repeat
    press_mode(1, 1'b0);
    for (int j = 1; j <= 11; j++) begin
      chk("blink", visivel, ((j / 4) % 2) == 0);
      @(negedge clk);
    end
    btn_inc = 1'b1;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      chk("rep_hora", incrementa_hora, (j == 1) || (j == 21) || (j == 26) || (j == 31) || (j == 36));
      if (j == 40) btn_inc = 1'b0;
    end

    // simultaneous mode and increment edges
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    @(negedge clk);
    chk("simul_modo", {30'd0, modo}, 2);
    chk("simul_hora", incrementa_hora, 0);
    chk("simul_min", incrementa_min, 0);
    btn_mode = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      chk("simul_hold_min", incrementa_min, 0);
    end
    btn_inc = 1'b0;
    @(negedge clk);

    // btn_inc ignored in RUN
    press_mode(0, 1'b1);
    for (int j = 0; j < 25; j++) begin
      btn_inc = j[2];
      @(negedge clk);
      chk("runinc_hora", incrementa_hora, 0);
      chk("runinc_min", incrementa_min, 0);
    end
    btn_inc = 1'b0;
    @(negedge clk);

    // reset in SET_M with both buttons held through release
    press_mode(1, 1'b0);
    press_mode(2, 1'b0);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst2_modo", {30'd0, modo}, 0);
    chk("rst2_vis", visivel, 1);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("rst2_modo_hold", {30'd0, modo}, 0);
      chk("rst2_seg", incrementa_seg, j == 10);
      chk("rst2_inc", {30'd0, incrementa_min, incrementa_hora}, 0);
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 59) == 0) btn_inc = ~btn_inc;
      seg_max = 1'($urandom_range(0, 1));
      min_max = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 799) == 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
